// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encoding,
// default parameter values and the grant-index width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RWAIT  = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_ADDR_LEN  = 14;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_READ_LAT  = 1;
  // Wide enough for the largest supported read latency (4).
  localparam int CNT_W         = 3;

  function automatic int idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder: the first requester found scanning
// upward from ptr (wrapping) wins, reported both one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0] w_pos;

  // Scan ports in priority order starting at ptr; keep the first hit.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    w_pos = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = {1'b0, ptr} + (IW + 1)'(i);
      if (w_pos >= (IW + 1)'(N)) begin
        w_pos = w_pos - (IW + 1)'(N);
      end else begin
        w_pos = w_pos;
      end
      for (int k = 0; k < N; k++) begin
        if (!valid && (w_pos == (IW + 1)'(k)) && req[k]) begin
          gnt[k] = 1'b1;
          idx    = IW'(k);
          valid  = 1'b1;
        end else begin
          gnt[k] = gnt[k];
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM among NUM_PORTS
// requesters, one transaction in flight at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_LEN  = DEF_ADDR_LEN,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int READ_LAT  = DEF_READ_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_LEN-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_we,
  output logic [ADDR_LEN-1:0]           mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int IW = idx_w(NUM_PORTS);

  arb_state_e            r_state;
  logic [IW-1:0]         r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_PORTS-1:0]  r_sel;
  logic [NUM_PORTS-1:0]  r_gnt;
  logic [NUM_PORTS-1:0]  r_rvalid;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_mem_we;
  logic [ADDR_LEN-1:0]   r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;

  logic [NUM_PORTS-1:0]  w_gnt;
  logic [IW-1:0]         w_idx;
  logic                  w_valid;
  logic                  w_we_sel;
  logic [ADDR_LEN-1:0]   w_addr_sel;
  logic [DATA_W-1:0]     w_wdata_sel;
  logic [IW-1:0]         w_ptr_next;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr (
    .req   (req),
    .ptr   (r_ptr),
    .gnt   (w_gnt),
    .idx   (w_idx),
    .valid (w_valid)
  );

  // AND-OR mux of the winning port's command fields.
  always_comb begin
    w_we_sel    = 1'b0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_we_sel    = w_we_sel | (w_gnt[k] & we[k]);
      w_addr_sel  = w_addr_sel | ({ADDR_LEN{w_gnt[k]}} & addr[k*ADDR_LEN +: ADDR_LEN]);
      w_wdata_sel = w_wdata_sel | ({DATA_W{w_gnt[k]}} & wdata[k*DATA_W +: DATA_W]);
    end
  end

  // The port just granted drops to lowest priority next time.
  assign w_ptr_next = (w_idx == IW'(NUM_PORTS - 1)) ? '0 : (w_idx + IW'(1));

  // Transaction FSM with registered grant, memory command and read return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state     <= ST_ACCESS;
            r_sel       <= w_gnt;
            r_gnt       <= w_gnt;
            r_ptr       <= w_ptr_next;
            r_mem_we    <= w_we_sel;
            r_mem_addr  <= w_addr_sel;
            r_mem_wdata <= w_wdata_sel;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          r_mem_we <= 1'b0;
          if (r_mem_we) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RWAIT;
            r_cnt   <= CNT_W'(READ_LAT);
          end
        end
        ST_RWAIT: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state  <= ST_IDLE;
            r_rvalid <= r_sel;
            r_rdata  <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two configurations (2 ports / latency 1 and 4 ports /
// latency 3), each with a block-RAM model and a transaction-level reference.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic clk;
  int   total = 0;
  int   bad   = 0;
  bit   done [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NP    = (g == 0) ? 2 : 4;
    localparam int RL    = (g == 0) ? 1 : 3;
    localparam int RV_AT = (g == 0) ? 2 : 4;

    logic                 rst;
    logic [NP-1:0]        req, we, gnt, rvalid;
    logic [NP*AW-1:0]     addr;
    logic [NP*DW-1:0]     wdata;
    logic [DW-1:0]        rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we, busy;

    mem_arbiter #(
      .NUM_PORTS (NP),
      .ADDR_LEN  (AW),
      .DATA_W    (DW),
      .READ_LAT  (RL)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
    );

    // Block RAM with RL-cycle registered read.
    logic [DW-1:0] ram   [64] = '{default: '0};
    logic [DW-1:0] rpipe [RL] = '{default: '0};
    always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      rpipe[0] <= ram[mem_addr];
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[RL-1];

    // Reference: when free, pick next requester after the last winner and
    // schedule its grant / write / read-return on absolute cycle numbers.
    int            cyc = 0;
    int            free_at = 0;
    int            last = NP - 1;
    logic [NP-1:0] e_gnt  [64];
    logic [NP-1:0] e_rv   [64];
    logic          e_acc  [64];
    logic          e_we   [64];
    logic [AW-1:0] e_addr [64];
    logic [DW-1:0] e_wd   [64];
    logic [DW-1:0] e_rd   [64];
    logic [DW-1:0] shadow [64] = '{default: '0};
    logic [DW-1:0] hold;
    int            glog [$];

    function automatic int pick(input logic [NP-1:0] r, input int prev);
      for (int d = 1; d <= NP; d++) begin
        if (r[(prev + d) % NP]) return (prev + d) % NP;
      end
      return -1;
    endfunction

    always @(posedge clk or negedge rst) begin : model
      int k, c, s, a;
      if (rst !== 1'b1) begin
        free_at = 0;
        last    = NP - 1;
        for (int i = 0; i < 64; i++) begin
          e_gnt[i] = '0; e_rv[i] = '0; e_acc[i] = 1'b0; e_we[i] = 1'b0;
          e_addr[i] = '0; e_wd[i] = '0; e_rd[i] = '0;
        end
      end else begin
        s = cyc % 64;
        e_gnt[s] = '0; e_rv[s] = '0; e_acc[s] = 1'b0; e_we[s] = 1'b0;
        c = cyc + 1;
        if (cyc >= free_at && req != '0) begin
          k = pick(req, last);
          s = c % 64;
          a = int'(addr[k*AW +: AW]);
          e_gnt[s]  = NP'(1) << k;
          e_acc[s]  = 1'b1;
          e_we[s]   = we[k];
          e_addr[s] = addr[k*AW +: AW];
          e_wd[s]   = wdata[k*DW +: DW];
          if (we[k]) begin
            shadow[a] = wdata[k*DW +: DW];
            free_at   = c + 1;
          end else begin
            e_rv[(c + RL + 1) % 64] = NP'(1) << k;
            e_rd[(c + RL + 1) % 64] = shadow[a];
            free_at = c + RL + 1;
          end
          last = k;
        end
        cyc = c;
      end
    end

    always @(negedge clk) begin : compare
      int s;
      s = cyc % 64;
      if (rst !== 1'b1) begin
        hold = '0;
        chk($sformatf("c%0d rst gnt", g), 64'(gnt), 64'd0);
        chk($sformatf("c%0d rst rvalid", g), 64'(rvalid), 64'd0);
        chk($sformatf("c%0d rst busy", g), 64'(busy), 64'd0);
        chk($sformatf("c%0d rst mem_we", g), 64'(mem_we), 64'd0);
        chk($sformatf("c%0d rst rdata", g), 64'(rdata), 64'd0);
        chk($sformatf("c%0d rst mem_addr", g), 64'(mem_addr), 64'd0);
        chk($sformatf("c%0d rst mem_wdata", g), 64'(mem_wdata), 64'd0);
      end else begin
        if (e_rv[s] != '0) hold = e_rd[s];
        chk($sformatf("c%0d cyc%0d gnt", g, cyc), 64'(gnt), 64'(e_gnt[s]));
        chk($sformatf("c%0d cyc%0d rvalid", g, cyc), 64'(rvalid), 64'(e_rv[s]));
        chk($sformatf("c%0d cyc%0d busy", g, cyc), 64'(busy), 64'(cyc < free_at));
        chk($sformatf("c%0d cyc%0d mem_we", g, cyc), 64'(mem_we), 64'(e_acc[s] & e_we[s]));
        chk($sformatf("c%0d cyc%0d rdata", g, cyc), 64'(rdata), 64'(hold));
        if (e_acc[s]) chk($sformatf("c%0d cyc%0d mem_addr", g, cyc), 64'(mem_addr), 64'(e_addr[s]));
        if (e_acc[s] && e_we[s]) chk($sformatf("c%0d cyc%0d mem_wdata", g, cyc), 64'(mem_wdata), 64'(e_wd[s]));
      end
      for (int k = 0; k < NP; k++) if (gnt[k]) glog.push_back(k);
    end

    task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
    endtask

    task automatic drive(input int p, input logic r, input logic w, input int a, input logic [DW-1:0] d);
      req[p] = r;
      we[p]  = w;
      addr[p*AW +: AW]  = AW'(a);
      wdata[p*DW +: DW] = d;
    endtask

    task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 30) begin
        tick(1);
        n++;
      end
      chk($sformatf("c%0d idle timeout", g), 64'(busy), 64'd0);
    endtask

    function automatic int rot_exp(input int i);
      if (NP == 4) return (i == 0) ? 3 : (i == 1) ? 0 : (i == 2) ? 1 : 2;
      else         return (i == 0) ? 1 : 0;
    endfunction

    initial begin : stim
      int n, b;
      rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
      tick(3);
      rst = 1'b1;
      tick(1);
      chk($sformatf("c%0d post-reset busy", g), 64'(busy), 64'd0);

      // Single write: port 0, addr 12, data 2.
      drive(0, 1'b1, 1'b1, 12, 32'd2);
      tick(1);
      chk($sformatf("c%0d write gnt", g), 64'(gnt), 64'd1);
      req = '0; we = '0;
      tick(1);
      chk($sformatf("c%0d ram[12]", g), 64'(ram[12]), 64'd2);

      // Read back through port 1, measuring rvalid latency from ACCESS.
      drive(1, 1'b1, 1'b0, 12, 32'd0);
      tick(1);
      chk($sformatf("c%0d read gnt", g), 64'(gnt), 64'd2);
      req = '0;
      n = 0;
      while (rvalid == '0 && n < 10) begin
        tick(1);
        n++;
      end
      chk($sformatf("c%0d read latency", g), 64'(n), 64'(RV_AT));
      chk($sformatf("c%0d read rvalid", g), 64'(rvalid), 64'd2);
      chk($sformatf("c%0d read rdata", g), 64'(rdata), 64'd2);
      tick(1);
      chk($sformatf("c%0d rdata hold", g), 64'(rdata), 64'd2);
      wait_idle();

      // Contention between ports 0 and 1.
      b = glog.size();
      drive(0, 1'b1, 1'b1, 20, 32'h11);
      drive(1, 1'b1, 1'b1, 21, 32'h22);
      tick(8);
      req = '0; we = '0;
      wait_idle();
      chk($sformatf("c%0d contention count", g), 64'(glog.size() - b), 64'd4);
      for (int i = 0; i < 4; i++)
        chk($sformatf("c%0d contention #%0d", g, i), 64'((b + i < glog.size()) ? glog[b + i] : -1), 64'(i % 2));

      // Rotation: port NP-2 alone, then everybody.
      b = glog.size();
      drive(NP - 2, 1'b1, 1'b1, 30, 32'h33);
      tick(1);
      req = '0; we = '0;
      tick(1);
      for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, 40 + p, DW'(p + 100));
      tick(2 * NP);
      req = '0; we = '0;
      wait_idle();
      chk($sformatf("c%0d rotation count", g), 64'(glog.size() - b), 64'(NP + 1));
      for (int i = 0; i < NP; i++)
        chk($sformatf("c%0d rotation #%0d", g, i), 64'((b + 1 + i < glog.size()) ? glog[b + 1 + i] : -1), 64'(rot_exp(i)));

      // Withdrawal: port 1 asks only while port 0 is served.
      b = glog.size();
      drive(0, 1'b1, 1'b0, 12, 32'd0);
      tick(1);
      chk($sformatf("c%0d withdraw gnt0", g), 64'(gnt), 64'd1);
      req[0] = 1'b0; req[1] = 1'b1;
      tick(1);
      req[1] = 1'b0;
      wait_idle();
      tick(3);
      chk($sformatf("c%0d withdraw grants", g), 64'(glog.size() - b), 64'd1);
      chk($sformatf("c%0d withdraw idle", g), 64'(busy), 64'd0);

      // Reset during RWAIT of a port-1 read.
      drive(1, 1'b1, 1'b0, 12, 32'd0);
      tick(1);
      chk($sformatf("c%0d pre-reset gnt", g), 64'(gnt), 64'd2);
      req = '0;
      tick(1);
      rst = 1'b0;
      #1;
      chk($sformatf("c%0d abort busy", g), 64'(busy), 64'd0);
      chk($sformatf("c%0d abort rvalid", g), 64'(rvalid), 64'd0);
      tick(2);
      rst = 1'b1;
      drive(0, 1'b1, 1'b0, 5, 32'd0);
      drive(1, 1'b1, 1'b0, 6, 32'd0);
      tick(1);
      chk($sformatf("c%0d first grant after reset", g), 64'(gnt), 64'd1);
      req = '0;
      wait_idle();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
        for (int p = 0; p < NP; p++)
          drive(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 63), DW'($urandom));
        tick(1);
      end
      req = '0; we = '0;
      wait_idle();
      tick(RL + 3);
      done[g] = 1'b1;
    end
  end

  initial begin : summary
    int n;
    n = 0;
    while (!(done[0] && done[1]) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    chk("completion", {62'd0, done[1], done[0]}, 64'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
